// File: rtl/taus_seed_loader.sv
// taus_seed_loader
// Purpose: upstream seed loader for the dual-Tausworthe URNG wrapper.
//   Six 32-bit seed words arrive serially over a write port. Each word is
//   checked against its Tausworthe minimum-seed constraint. Accepted words go
//   into shadow registers, and all six are committed to s0..s5 together. The
//   generator is held in reset while a load is in progress, and then for
//   RST_HOLD further cycles, so its first outputs come from a valid state.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   load_start in   1   one-cycle request to begin (or restart) a 6-word load
//   wr_en      in   1   seed word strobe, honoured only while wr_ready=1
//   wr_data    in  32   seed word, loaded in order s0..s5
//   wr_ready   out  1   high in LOAD
//   seed_err   out  1   one-cycle pulse after a strobed word below its minimum
//   load_count out  3   words accepted so far in the current load
//   busy       out  1   high in LOAD or HOLD
//   gen_reset  out  1   reset to the URNG wrapper
//   run        out  1   high in RUN; URNG outputs are valid
//   s0..s5     out 32   committed seeds
//
// state | meaning
// HOLD  | generator held in reset for RST_HOLD cycles
// RUN   | generator free-running on committed seeds
// LOAD  | collecting seed words into shadow registers
module taus_seed_loader #(
  parameter logic [31:0] DEF_S0   = 32'h0000_1234,
  parameter logic [31:0] DEF_S1   = 32'h0000_5678,
  parameter logic [31:0] DEF_S2   = 32'h0000_9ABC,
  parameter logic [31:0] DEF_S3   = 32'h0000_DEF0,
  parameter logic [31:0] DEF_S4   = 32'h0001_2345,
  parameter logic [31:0] DEF_S5   = 32'h0006_7890,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        seed_err,
  output logic [2:0]  load_count,
  output logic        busy,
  output logic        gen_reset,
  output logic        run,
  output logic [31:0] s0,
  output logic [31:0] s1,
  output logic [31:0] s2,
  output logic [31:0] s3,
  output logic [31:0] s4,
  output logic [31:0] s5
);

  typedef enum logic [1:0] {HOLD, RUN, LOAD} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

  state_t           state;
  logic [7:0]       hold_cnt;
  logic [4:0][31:0] shadow;
  logic [31:0]      min_val;
  logic             word_ok;

  // Each Tausworthe component has its own minimum; the pattern repeats for
  // the second generator (words 3..5).
  always_comb begin
    min_val = 32'd16;
    case (load_count)
      3'd0, 3'd3: min_val = 32'd2;
      3'd1, 3'd4: min_val = 32'd8;
      default:    min_val = 32'd16;
    endcase
  end

  assign word_ok = (wr_data >= min_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      shadow     <= '0;
      s0         <= DEF_S0;
      s1         <= DEF_S1;
      s2         <= DEF_S2;
      s3         <= DEF_S3;
      s4         <= DEF_S4;
      s5         <= DEF_S5;
      gen_reset  <= 1'b1;
      run        <= 1'b0;
      busy       <= 1'b1;
      wr_ready   <= 1'b0;
      seed_err   <= 1'b0;
      load_count <= '0;
    end else begin
      seed_err <= 1'b0;
      case (state)
        HOLD, RUN: begin
          if (load_start) begin
            state      <= LOAD;
            hold_cnt   <= '0;
            load_count <= '0;
            gen_reset  <= 1'b1;
            run        <= 1'b0;
            busy       <= 1'b1;
            wr_ready   <= 1'b1;
          end else if (state == HOLD) begin
            if (hold_cnt == HOLD_LAST) begin
              state     <= RUN;
              hold_cnt  <= '0;
              gen_reset <= 1'b0;
              run       <= 1'b1;
              busy      <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end
        LOAD: begin
          // A restart takes priority over any word strobed in the same cycle.
          if (load_start) begin
            load_count <= '0;
          end else if (wr_en) begin
            if (!word_ok) begin
              seed_err <= 1'b1;
            end else if (load_count == 3'd5) begin
              // Last word goes straight to s5; the rest come from the shadows.
              s0         <= shadow[0];
              s1         <= shadow[1];
              s2         <= shadow[2];
              s3         <= shadow[3];
              s4         <= shadow[4];
              s5         <= wr_data;
              load_count <= '0;
              state      <= HOLD;
              hold_cnt   <= '0;
              wr_ready   <= 1'b0;
            end else begin
              shadow[load_count] <= wr_data;
              load_count         <= load_count + 3'd1;
            end
          end
        end
        default: begin
          state     <= HOLD;
          hold_cnt  <= '0;
          gen_reset <= 1'b1;
          run       <= 1'b0;
          busy      <= 1'b1;
          wr_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/taus_seed_loader.md
Name: taus_seed_loader

Overview:
- Upstream stage of the dual-Tausworthe URNG wrapper.
- Accepts six 32-bit seed words serially over a simple write port and checks each against the Tausworthe minimum-seed constraints.
- Presents the six seeds as stable parallel outputs (s0..s5) and controls the generator's reset.
- Holds the generator in reset while seeds are being loaded, then for a fixed settle period, then releases it so the uniform outputs start from a known, valid state.

Parameters:
- DEF_S0, 32'h0000_1234: default seed s0, used after reset; must be >= 2.
- DEF_S1, 32'h0000_5678: default seed s1; must be >= 8.
- DEF_S2, 32'h0000_9ABC: default seed s2; must be >= 16.
- DEF_S3, 32'h0000_DEF0: default seed s3; must be >= 2.
- DEF_S4, 32'h0001_2345: default seed s4; must be >= 8.
- DEF_S5, 32'h0006_7890: default seed s5; must be >= 16.
- RST_HOLD, 4: number of cycles gen_reset stays high in HOLD; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle request to begin a new 6-word seed load.
- wr_en  in  1  seed word strobe; ignored when wr_ready=0.
- wr_data  in  32  seed word; words are loaded in order s0,s1,s2,s3,s4,s5.
- wr_ready  out  1  high in LOAD state only.
- seed_err  out  1  one-cycle pulse when a strobed word violates its minimum.
- load_count  out  3  number of words accepted in the current load (0..5).
- busy  out  1  high in LOAD or HOLD.
- gen_reset  out  1  drives the URNG wrapper reset.
- run  out  1  high in RUN; the URNG outputs are valid.
- s0,s1,s2,s3,s4,s5  out  32 each  committed seeds to the URNG wrapper.

Behaviour:
- States: HOLD, RUN, LOAD. All outputs are registered.
- Reset (clk edge with reset=1):
  - state=HOLD, hold_cnt=0.
  - s0..s5=DEF_S0..DEF_S5; shadow regs cleared.
  - gen_reset=1, run=0, busy=1, wr_ready=0, seed_err=0, load_count=0.
- HOLD:
  - gen_reset=1; hold_cnt increments each cycle.
  - When hold_cnt reaches RST_HOLD-1: next state RUN, hold_cnt cleared.
  - Result: gen_reset is high for exactly RST_HOLD cycles after reset release or after a commit.
- RUN: gen_reset=0, run=1, busy=0. Stays in RUN until load_start.
- load_start in HOLD or RUN:
  - Next state LOAD, load_count=0, gen_reset=1, run=0, wr_ready=1.
  - s0..s5 keep their old values until commit.
- LOAD, wr_en=1:
  - Word index k=load_count. The minimum is 2 for k in {0,3}, 8 for k in {1,4}, 16 for k in {2,5}.
  - wr_data >= minimum: write shadow[k]; load_count increments.
  - wr_data < minimum: discard the word; load_count unchanged; seed_err=1 on the next cycle for exactly one cycle.
- Commit: on acceptance of word 5, at the same edge:
  - s0..s5 <= {shadow0..4, wr_data}.
  - load_count=0, state=HOLD, wr_ready=0. seed_err stays 0.
- load_start in LOAD (including the same cycle as wr_en):
  - Restart wins: the strobed word is discarded and load_count=0.
  - s0..s5 are unchanged and the block stays in LOAD.
- wr_en outside LOAD: ignored, with no seed_err.
- Reset mid-LOAD: the partial load is dropped and s0..s5 revert to the DEF values (normal reset behaviour).
- Invariant: s0..s5 never change while gen_reset=0.

Test Plan:
1. Reset release with RST_HOLD=4 -> gen_reset=1 for cycles 1-4, run=1 from cycle 5; s0=32'h1234 and s5=32'h67890 throughout.
2. In RUN, pulse load_start, then write 6 valid words 2,8,16,3,9,17 on consecutive cycles:
   - wr_ready=1 and gen_reset=1 during the load;
   - s0..s5 update to 2,8,16,3,9,17 on the 6th write edge;
   - gen_reset stays high 4 more cycles, then run=1.
3. In LOAD, write 1 as word 0 -> seed_err pulses 1 cycle, load_count stays 0; then write 7 as word 1 position after a valid 2 -> seed_err pulses, load_count stays 1.
4. After 3 valid words, assert load_start together with wr_en (data 100) -> load_count=0, word discarded, s0..s5 unchanged, still LOAD.
5. Assert reset after 4 accepted words -> s0..s5=DEF values, HOLD for 4 cycles, then RUN; wr_en in RUN with data 0 -> no seed_err, no state change.
